// File: rtl/ex_mem_skid_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_skid_reg
//
// Pipeline register between the EX and MEM stages, built as a two-entry skid
// buffer. The "main" entry drives the mem_* outputs and a "skid" entry catches
// the one extra instruction that EX may hand over in the cycle MEM stalls.
// ex_ready comes from registered occupancy only, so no combinational path
// runs from mem_ready back to EX, and no ex_* input reaches a mem_* output
// without passing through a register.
//
// Ports
//   clk, rst           : clock (rising edge) and async active-high reset
//   flush              : synchronous kill of every held entry
//   ex_valid/ex_ready  : EX-side handshake
//   ex_alu_result      : ALU result / memory address        (DATA_WIDTH)
//   ex_store_data      : forwarded rs2 value for stores      (DATA_WIDTH)
//   ex_rd_addr         : destination register                (5)
//   ex_reg_write, ex_mem_read, ex_mem_write : control bits
//   ex_instr           : instruction word for debug tracking (32)
//   mem_valid/mem_ready: MEM-side handshake
//   mem_*              : the held main entry; control bits read as 0 and
//                        mem_instr reads as NOP_INSTR whenever mem_valid is 0
// ---------------------------------------------------------------------------
module ex_mem_skid_reg #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [DATA_WIDTH-1:0] ex_alu_result,
   input  logic [DATA_WIDTH-1:0] ex_store_data,
   input  logic [4:0]            ex_rd_addr,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [31:0]           ex_instr,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] mem_alu_result,
   output logic [DATA_WIDTH-1:0] mem_store_data,
   output logic [4:0]            mem_rd_addr,
   output logic                  mem_reg_write,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic [31:0]           mem_instr
);

   localparam int ENTRY_W = 2 * DATA_WIDTH + 5 + 3 + 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occState_t;

   occState_t          state_q;
   logic [ENTRY_W-1:0] main_q;
   logic [ENTRY_W-1:0] skid_q;
   logic [ENTRY_W-1:0] captureEntry_d;
   logic               doAccept;
   logic               doRelease;

   logic [DATA_WIDTH-1:0] mainAlu;
   logic [DATA_WIDTH-1:0] mainStore;
   logic [4:0]            mainRd;
   logic                  mainRegWrite;
   logic                  mainMemRead;
   logic                  mainMemWrite;
   logic [31:0]           mainInstr;

   // Handshake decode. Valid/ready are both pure decodes of the registered
   // occupancy, which keeps mem_ready out of the ex_ready timing path.
   assign mem_valid = (state_q != EMPTY);
   assign ex_ready  = (state_q != FULL);
   assign doAccept  = ex_valid & ex_ready;
   assign doRelease = mem_valid & mem_ready;

   // The entry as it will be stored. A write to x0 is squashed at capture so
   // forwarding logic downstream never sees a pointless register write.
   assign captureEntry_d = {ex_alu_result,
                            ex_store_data,
                            ex_rd_addr,
                            ex_reg_write & (ex_rd_addr != 5'd0),
                            ex_mem_read,
                            ex_mem_write,
                            ex_instr};

   assign {mainAlu, mainStore, mainRd, mainRegWrite, mainMemRead,
           mainMemWrite, mainInstr} = main_q;

   // Occupancy FSM and storage. Flush only drops the valid state; the data
   // registers keep stale contents because the output masking below hides
   // them. In ONE with simultaneous accept and release the new entry goes
   // straight into main so a full-rate stream never touches the skid slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         state_q <= EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (doAccept) begin
                  main_q  <= captureEntry_d;
                  state_q <= ONE;
               end
            end
            ONE: begin
               if (doAccept && doRelease) begin
                  main_q <= captureEntry_d;
               end else if (doAccept) begin
                  skid_q  <= captureEntry_d;
                  state_q <= FULL;
               end else if (doRelease) begin
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               if (doRelease) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
               end
            end
            default: begin
               state_q <= EMPTY;
            end
         endcase
      end
   end

   // Output stage. Control bits and the instruction word are masked by
   // mem_valid so a bubble can never write the register file or memory and
   // always traces as a NOP. Data fields pass through unmasked.
   assign mem_alu_result = mainAlu;
   assign mem_store_data = mainStore;
   assign mem_rd_addr    = mainRd;
   assign mem_reg_write  = mainRegWrite & mem_valid;
   assign mem_mem_read   = mainMemRead & mem_valid;
   assign mem_mem_write  = mainMemWrite & mem_valid;
   assign mem_instr      = mem_valid ? mainInstr : NOP_INSTR;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_skid_reg
//
// Self-checking bench for ex_mem_skid_reg. The reference model is a plain
// queue holding at most two entries: ready means fewer than two are held,
// a release pops the head and an accept pushes at the tail, and a flush or
// reset empties it. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ex_mem_skid_reg;

   localparam int          DW  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          ex_valid;
   logic          ex_ready;
   logic [DW-1:0] ex_alu_result;
   logic [DW-1:0] ex_store_data;
   logic [4:0]    ex_rd_addr;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic [31:0]   ex_instr;
   logic          mem_valid;
   logic          mem_ready;
   logic [DW-1:0] mem_alu_result;
   logic [DW-1:0] mem_store_data;
   logic [4:0]    mem_rd_addr;
   logic          mem_reg_write;
   logic          mem_mem_read;
   logic          mem_mem_write;
   logic [31:0]   mem_instr;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [31:0] instr;
   } entry_t;

   entry_t modelQ[$];
   int     checkCount = 0;
   int     passCount  = 0;

   ex_mem_skid_reg #(.DATA_WIDTH(DW), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_alu_result  (ex_alu_result),
      .ex_store_data  (ex_store_data),
      .ex_rd_addr     (ex_rd_addr),
      .ex_reg_write   (ex_reg_write),
      .ex_mem_read    (ex_mem_read),
      .ex_mem_write   (ex_mem_write),
      .ex_instr       (ex_instr),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_alu_result (mem_alu_result),
      .mem_store_data (mem_store_data),
      .mem_rd_addr    (mem_rd_addr),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_read   (mem_mem_read),
      .mem_mem_write  (mem_mem_write),
      .mem_instr      (mem_instr)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds an entry with chosen ALU value and destination, random elsewhere.
   function automatic entry_t makeEntry(input logic [31:0] alu, input logic [4:0] rd,
                                        input logic rw);
      entry_t e;
      e.alu   = alu;
      e.store = $urandom;
      e.rd    = rd;
      e.rw    = rw;
      e.mr    = 1'($urandom_range(0, 1));
      e.mw    = 1'($urandom_range(0, 1));
      e.instr = $urandom;
      return e;
   endfunction

   function automatic entry_t randEntry();
      return makeEntry($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
   endfunction

   // What the outputs should read given the model queue.
   function automatic logic [105:0] expectedVec();
      entry_t h;
      if (modelQ.size() == 0) return {1'b0, 1'b1, 3'b000, NOP, 5'd0, 32'd0, 32'd0};
      h = modelQ[0];
      return {1'b1, (modelQ.size() < 2), h.rw, h.mr, h.mw, h.instr, h.rd, h.alu, h.store};
   endfunction

   // Observed outputs, with data fields masked while no entry is valid.
   function automatic logic [105:0] observedVec();
      return {mem_valid, ex_ready, mem_reg_write, mem_mem_read, mem_mem_write, mem_instr,
              mem_valid ? mem_rd_addr : 5'd0,
              mem_valid ? mem_alu_result : 32'd0,
              mem_valid ? mem_store_data : 32'd0};
   endfunction

   // Drives one cycle of inputs, advances the model across the rising edge
   // and returns at the following falling edge.
   task automatic applyStimulus(input logic fl, input logic ev, input logic mr,
                                input entry_t e);
      bit     acc;
      bit     rel;
      entry_t s;
      flush         = fl;
      ex_valid      = ev;
      mem_ready     = mr;
      ex_alu_result = e.alu;
      ex_store_data = e.store;
      ex_rd_addr    = e.rd;
      ex_reg_write  = e.rw;
      ex_mem_read   = e.mr;
      ex_mem_write  = e.mw;
      ex_instr      = e.instr;
      @(posedge clk);
      acc = ev && (modelQ.size() < 2);
      rel = mr && (modelQ.size() > 0);
      if (fl) begin
         modelQ.delete();
      end else begin
         if (rel) void'(modelQ.pop_front());
         if (acc) begin
            s    = e;
            s.rw = e.rw && (e.rd != 5'd0);
            modelQ.push_back(s);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      entry_t x;
      #2;
      checkCount++;
      if ({mem_valid, ex_ready, mem_reg_write, mem_mem_read, mem_mem_write} !== 5'b01000) begin
         $display("[TB] FAIL reset_ctrl: got %b expected 01000",
                  {mem_valid, ex_ready, mem_reg_write, mem_mem_read, mem_mem_write});
      end else passCount++;
      checkCount++;
      if ({mem_alu_result, mem_store_data, mem_rd_addr} !== 69'd0) begin
         $display("[TB] FAIL reset_data: got %h expected 0",
                  {mem_alu_result, mem_store_data, mem_rd_addr});
      end else passCount++;
      checkCount++;
      if (mem_instr !== NOP) begin
         $display("[TB] FAIL reset_instr: got %h expected %h", mem_instr, NOP);
      end else passCount++;
      ex_valid = 1'b1;
      @(negedge clk);
      checkCount++;
      if ({mem_valid, ex_ready} !== 2'b01) begin
         $display("[TB] FAIL reset_held: got %b expected 01", {mem_valid, ex_ready});
      end else passCount++;
      rst = 1'b0;
      modelQ.delete();
      x = makeEntry(32'hA5A5_0001, 5'd3, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, x);
      checkCount++;
      if ({mem_valid, mem_alu_result} !== {1'b1, 32'hA5A5_0001}) begin
         $display("[TB] FAIL first_accept: got %b/%h expected 1/a5a50001",
                  mem_valid, mem_alu_result);
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, x);
      checkCount++;
      if (observedVec() !== expectedVec()) begin
         $display("[TB] FAIL reset_drain: got %h expected %h", observedVec(), expectedVec());
      end else passCount++;
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, makeEntry(i, 5'd1, 1'b1));
         checkCount++;
         if ({mem_valid, ex_ready, mem_alu_result} !== {1'b1, 1'b1, 32'(i)}) begin
            $display("[TB] FAIL stream_%0d: got %b%b/%0d expected 11/%0d",
                     i, mem_valid, ex_ready, mem_alu_result, i);
         end else passCount++;
      end
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
      checkCount++;
      if (mem_valid !== 1'b0) begin
         $display("[TB] FAIL stream_drain: got valid %b expected 0", mem_valid);
      end else passCount++;
   endtask

   task automatic test_backpressure();
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'h100, 5'd4, 1'b1));
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'h200, 5'd5, 1'b1));
      checkCount++;
      if ({mem_valid, ex_ready, mem_alu_result} !== {2'b10, 32'h100}) begin
         $display("[TB] FAIL bp_full: got %b%b/%h expected 10/100",
                  mem_valid, ex_ready, mem_alu_result);
      end else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'h300, 5'd6, 1'b1));
      checkCount++;
      if (observedVec() !== expectedVec()) begin
         $display("[TB] FAIL bp_hold: got %h expected %h", observedVec(), expectedVec());
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
      checkCount++;
      if ({mem_valid, ex_ready, mem_alu_result} !== {2'b11, 32'h200}) begin
         $display("[TB] FAIL bp_second: got %b%b/%h expected 11/200",
                  mem_valid, ex_ready, mem_alu_result);
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
      checkCount++;
      if ({mem_valid, ex_ready} !== 2'b01) begin
         $display("[TB] FAIL bp_empty: got %b%b expected 01", mem_valid, ex_ready);
      end else passCount++;
   endtask

   task automatic test_x0_write();
      applyStimulus(1'b0, 1'b1, 1'b1, makeEntry(32'h10, 5'd0, 1'b1));
      checkCount++;
      if ({mem_valid, mem_reg_write} !== 2'b10) begin
         $display("[TB] FAIL x0_write: got %b%b expected 10", mem_valid, mem_reg_write);
      end else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b1, makeEntry(32'h11, 5'd7, 1'b1));
      checkCount++;
      if ({mem_valid, mem_reg_write, mem_rd_addr} !== {2'b11, 5'd7}) begin
         $display("[TB] FAIL x7_write: got %b%b/%0d expected 11/7",
                  mem_valid, mem_reg_write, mem_rd_addr);
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
   endtask

   task automatic test_flush();
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'hF1, 5'd1, 1'b1));
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'hF2, 5'd2, 1'b1));
      applyStimulus(1'b1, 1'b1, 1'b1, makeEntry(32'hF3, 5'd3, 1'b1));
      checkCount++;
      if ({mem_valid, ex_ready, mem_reg_write, mem_mem_read, mem_mem_write, mem_instr}
          !== {5'b01000, 32'h13}) begin
         $display("[TB] FAIL flush_full: got %b%b%b%b%b/%h expected 01000/13", mem_valid,
                  ex_ready, mem_reg_write, mem_mem_read, mem_mem_write, mem_instr);
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'hF4, 5'd4, 1'b1));
      applyStimulus(1'b1, 1'b1, 1'b0, makeEntry(32'hF5, 5'd5, 1'b1));
      checkCount++;
      if (mem_valid !== 1'b0) begin
         $display("[TB] FAIL flush_accept: got valid %b expected 0", mem_valid);
      end else passCount++;
      applyStimulus(1'b0, 1'b1, 1'b1, makeEntry(32'hF6, 5'd6, 1'b1));
      checkCount++;
      if ({mem_valid, mem_alu_result} !== {1'b1, 32'hF6}) begin
         $display("[TB] FAIL flush_after: got %b/%h expected 1/f6", mem_valid, mem_alu_result);
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
   endtask

   task automatic test_async_reset();
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'hB1, 5'd9, 1'b1));
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'hB2, 5'd10, 1'b1));
      ex_valid  = 1'b0;
      mem_ready = 1'b1;
      #2;
      rst = 1'b1;
      modelQ.delete();
      #1;
      checkCount++;
      if ({mem_valid, mem_reg_write, ex_ready} !== 3'b001) begin
         $display("[TB] FAIL async_reset: got %b%b%b expected 001",
                  mem_valid, mem_reg_write, ex_ready);
      end else passCount++;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, makeEntry(32'hB3, 5'd11, 1'b1));
      checkCount++;
      if (observedVec() !== expectedVec()) begin
         $display("[TB] FAIL async_after: got %h expected %h", observedVec(), expectedVec());
      end else passCount++;
      applyStimulus(1'b0, 1'b0, 1'b1, randEntry());
   endtask

   task automatic test_soak();
      int  errs;
      logic fl;
      logic ev;
      logic mr;
      errs = 0;
      for (int c = 0; c < 10000; c++) begin
         fl = ($urandom_range(0, 99) < 3);
         ev = ($urandom_range(0, 99) < 70);
         mr = ($urandom_range(0, 99) < 60);
         applyStimulus(fl, ev, mr, randEntry());
         checkCount++;
         if (observedVec() !== expectedVec()) begin
            if (errs < 10) begin
               $display("[TB] FAIL soak_cycle_%0d: got %h expected %h",
                        c, observedVec(), expectedVec());
            end
            errs++;
         end else passCount++;
      end
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      ex_valid = 1'b0;
      mem_ready = 1'b0;
      ex_alu_result = '0;
      ex_store_data = '0;
      ex_rd_addr = '0;
      ex_reg_write = 1'b0;
      ex_mem_read = 1'b0;
      ex_mem_write = 1'b0;
      ex_instr = '0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_x0_write();
      test_flush();
      test_async_reset();
      test_soak();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
